// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the icache/dcache memory arbiter: memory latency
// and the client identifier used by the grant logic and the top level.
package mem_arbiter_pkg;

  // Cycles from the memory sampling a request to it raising mem_ready.
  localparam int MEMORY_DELAY_CYCLES = 4;

  typedef enum logic {
    CL_IC = 1'b0,
    CL_DC = 1'b1
  } client_e;

endpackage

// File: rtl/mem_arbiter_grant_select.sv
// Grant selection between the icache and dcache request lines. A lone
// request always wins; on a conflict the priority pointer decides.
module arb_grant_select
  import mem_arbiter_pkg::*;
(
  input  logic    ic_req,
  input  logic    dc_req,
  input  client_e prio,
  output client_e grant,
  output logic    valid
);

  // Pick the single requester, or the preferred client when both ask.
  always_comb begin
    valid = ic_req | dc_req;
    grant = prio;
    if (ic_req && !dc_req) begin
      grant = CL_IC;
    end else if (dc_req && !ic_req) begin
      grant = CL_DC;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-client line arbiter in front of a single memory port. The icache only
// fills; the dcache fills or writes back. One transaction is in flight at a
// time and walks IDLE -> REQ -> WAIT -> DRAIN -> RESP.
// Build option: define ARB_ROUND_ROBIN_EN to alternate conflict priority
// after each completed grant; otherwise the dcache always wins conflicts.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic              ic_abort,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wr_data,
  output logic              dc_done,
  output logic [LINE_W-1:0] rd_line,
  output logic              mem_requested,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wr_data,
  output logic              mem_reset_req,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rd_data
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t  state_q, state_d;
  client_e grant_q;
  client_e prio_q;
  client_e sel_grant;
  logic    sel_valid;
  logic    abort_hit;

  arb_grant_select u_grant (
    .ic_req (ic_req),
    .dc_req (dc_req),
    .prio   (prio_q),
    .grant  (sel_grant),
    .valid  (sel_valid)
  );

`ifdef ARB_ROUND_ROBIN_EN
  // Hand preference to the other client once a grant has completed.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= CL_DC;
    end else if (state_q == RESP) begin
      prio_q <= (grant_q == CL_DC) ? CL_IC : CL_DC;
    end
  end
`else
  assign prio_q = CL_DC;
`endif

  // An icache abort only counts while the icache owns the request phase.
  assign abort_hit = ic_abort && (grant_q == CL_IC) &&
                     ((state_q == REQ) || (state_q == WAIT));

  // Next state plus the combinational memory handshake outputs.
  always_comb begin
    state_d       = state_q;
    mem_requested = 1'b0;
    mem_reset_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_valid) state_d = REQ;
      end
      REQ: begin
        if (abort_hit) begin
          mem_reset_req = 1'b1;
          state_d       = IDLE;
        end else begin
          mem_requested = 1'b1;
          state_d       = WAIT;
        end
      end
      WAIT: begin
        if (abort_hit) begin
          mem_reset_req = 1'b1;
          state_d       = IDLE;
        end else begin
          // Drop the request in the ready cycle so it is never seen twice.
          mem_requested = !mem_ready;
          if (mem_ready) state_d = DRAIN;
        end
      end
      DRAIN:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched transaction fields, fill data and done pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= CL_IC;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      rd_line     <= '0;
      ic_done     <= 1'b0;
      dc_done     <= 1'b0;
    end else begin
      state_q <= state_d;
      ic_done <= 1'b0;
      dc_done <= 1'b0;
      if ((state_q == IDLE) && sel_valid) begin
        grant_q <= sel_grant;
        if (sel_grant == CL_DC) begin
          mem_we      <= dc_we;
          mem_addr    <= dc_addr;
          mem_wr_data <= dc_wr_data;
        end else begin
          mem_we      <= 1'b0;
          mem_addr    <= ic_addr;
          mem_wr_data <= '0;
        end
      end
      if (state_q == RESP) begin
        if (!mem_we) rd_line <= mem_rd_data;
        if (grant_q == CL_DC) dc_done <= 1'b1;
        else                  ic_done <= 1'b1;
      end
    end
  end

endmodule
